// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: debounces a 10-key pad, drives the priority encoder and
// shifts BCD digits into a 4-digit MM:SS register. Optional idle auto-clear: ENTRY_TIMEOUT_EN.
module keypad_entry_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  keypad,
  input  logic [3:0]  enc_bcd,
  input  logic        enc_none,
  output logic        enc_enablen,
  input  logic        lock,
  input  logic        clear,
  output logic        digit_strobe,
  output logic [3:0]  digit_value,
  output logic [15:0] time_bcd,
  output logic [2:0]  digit_count,
  output logic        entry_full,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_DEBOUNCE     = 3'd1;
  localparam logic [2:0] S_ACCEPT       = 3'd2;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] S_LOCKED       = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [9:0]  snap_q, snap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] time_q, time_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  value_q, value_d;
  logic        valid_key;

  assign valid_key = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid_key) begin
          snap_d  = keypad;
          cnt_d   = 16'd1;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (keypad != snap_q)             state_d = S_IDLE;
        else if (cnt_q == DEBOUNCE_CYCLES) state_d = S_ACCEPT;
        else                              cnt_d   = cnt_q + 16'd1;
      end
      S_ACCEPT:       state_d = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (enc_none) state_d = S_IDLE;
      S_LOCKED:       if (!lock) state_d = S_WAIT_RELEASE;
      default:        state_d = S_IDLE;
    endcase
    // Lock overrides every other transition and drops any press in flight.
    if (lock && state_q != S_LOCKED) state_d = S_LOCKED;
  end

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    time_d  = time_q;
    count_d = count_q;
    value_d = value_q;
    if (state_q == S_ACCEPT) begin
      value_d = enc_bcd;
      if (count_q < 3'd4) begin
        time_d  = {time_q[11:0], enc_bcd};
        count_d = count_q + 3'd1;
      end
    end
    // Clear is applied after the shift so it wins over a digit accepted this cycle.
    if (clear && state_q != S_LOCKED) begin
      time_d  = 16'd0;
      count_d = 3'd0;
    end
`ifdef ENTRY_TIMEOUT_EN
    timeout_d  = 1'b0;
    idle_cnt_d = 32'd0;
    if (state_q == S_IDLE && state_d == S_IDLE && count_q != 3'd0) begin
      if (idle_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
        timeout_d = 1'b1;
        time_d    = 16'd0;
        count_d   = 3'd0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= 10'd0;
      cnt_q   <= 16'd0;
      time_q  <= 16'd0;
      count_q <= 3'd0;
      value_q <= 4'd0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      count_q <= count_d;
      value_q <= value_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  logic timeout_param_unused;
  assign timeout_param_unused = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign enc_enablen  = !(state_q == S_DEBOUNCE || state_q == S_ACCEPT);
  assign digit_strobe = (state_q == S_ACCEPT);
  assign digit_value  = value_q;
  assign time_bcd     = time_q;
  assign digit_count  = count_q;
  assign entry_full   = (count_q == 3'd4);

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20;
// the keypad encoder is modelled behaviourally. Define ENTRY_TIMEOUT_EN to cover auto-clear.
module tb_keypad_entry_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  keypad;
  logic [3:0]  enc_bcd;
  logic        enc_none;
  logic        enc_enablen;
  logic        lock;
  logic        clear;
  logic        digit_strobe;
  logic [3:0]  digit_value;
  logic [15:0] time_bcd;
  logic [2:0]  digit_count;
  logic        entry_full;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int n_strobe = 0;
  int n_enable_low = 0;
  int n_timeout = 0;

  always #5 clk = ~clk;

  keypad_entry_controller #(.DEBOUNCE_CYCLES(16'd4), .TIMEOUT_CYCLES(32'd20)) dut (
    .clk(clk), .rst_n(rst_n), .keypad(keypad), .enc_bcd(enc_bcd), .enc_none(enc_none),
    .enc_enablen(enc_enablen), .lock(lock), .clear(clear), .digit_strobe(digit_strobe),
    .digit_value(digit_value), .time_bcd(time_bcd), .digit_count(digit_count),
    .entry_full(entry_full), .timeout(timeout)
  );

  // Behavioural priority encoder: highest pressed key wins, data_valid follows the pad.
  always_comb begin
    enc_bcd = 4'd0;
    for (int i = 0; i < 10; i++) if (keypad[i]) enc_bcd = 4'(i);
  end
  assign enc_none = (keypad == 10'd0);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (digit_strobe) n_strobe++;
    if (!enc_enablen) n_enable_low++;
    if (timeout)      n_timeout++;
  endtask

  task automatic press_digit(input int d);
    keypad = 10'd1 << d;
    repeat (5) step();
    check($sformatf("strobe_key%0d", d), {15'd0, digit_strobe}, 16'd1);
    step();
    check($sformatf("value_key%0d", d), {12'd0, digit_value}, 16'(d));
    keypad = 10'd0;
    step();
    step();
  endtask

  initial begin
    int s0, e0, first;
    rst_n  = 1'b0;
    keypad = 10'd0;
    lock   = 1'b0;
    clear  = 1'b0;
    step();
    step();
    check("rst_enablen", {15'd0, enc_enablen}, 16'd1);
    check("rst_strobe",  {15'd0, digit_strobe}, 16'd0);
    check("rst_time",    time_bcd, 16'h0000);
    check("rst_count",   {13'd0, digit_count}, 16'd0);
    check("rst_full",    {15'd0, entry_full}, 16'd0);
    check("rst_timeout", {15'd0, timeout}, 16'd0);
    rst_n = 1'b1;
    step();

    // Single key 5 held 12 cycles: exactly one strobe, five clocks after the press.
    s0 = n_strobe;
    first = 0;
    keypad = 10'b0000100000;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (digit_strobe && first == 0) first = i;
      if (i == 2) check("t1_enablen_debounce", {15'd0, enc_enablen}, 16'd0);
    end
    keypad = 10'd0;
    step();
    step();
    check("t1_strobe_count", 16'(n_strobe - s0), 16'd1);
    check("t1_strobe_cycle", 16'(first), 16'd5);
    check("t1_value", {12'd0, digit_value}, 16'd5);
    check("t1_time", time_bcd, 16'h0005);
    check("t1_count", {13'd0, digit_count}, 16'd1);

    // Four digits fill the entry; a fifth strobes but is not stored.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t2_clear_time", time_bcd, 16'h0000);
    check("t2_clear_count", {13'd0, digit_count}, 16'd0);
    press_digit(1);
    press_digit(2);
    press_digit(3);
    press_digit(0);
    check("t2_time", time_bcd, 16'h1230);
    check("t2_full", {15'd0, entry_full}, 16'd1);
    press_digit(7);
    check("t2_time_after_7", time_bcd, 16'h1230);
    check("t2_count_after_7", {13'd0, digit_count}, 16'd4);

    // Bouncing contact never completes the debounce window.
    clear = 1'b1;
    step();
    clear = 1'b0;
    s0 = n_strobe;
    keypad = 10'd1 << 3;
    step(); step();
    keypad = 10'd0;
    step();
    keypad = 10'd1 << 3;
    step(); step();
    keypad = 10'd0;
    repeat (8) step();
    check("t3_no_strobe", 16'(n_strobe - s0), 16'd0);
    check("t3_count", {13'd0, digit_count}, 16'd0);

    // Two keys at once are not one-hot and are ignored.
    s0 = n_strobe;
    e0 = n_enable_low;
    keypad = 10'b0000000110;
    repeat (20) step();
    keypad = 10'd0;
    step();
    check("t4_no_strobe", 16'(n_strobe - s0), 16'd0);
    check("t4_enablen_high", 16'(n_enable_low - e0), 16'd0);

    // Lock mid-debounce discards the press; key held across unlock is not taken.
    s0 = n_strobe;
    keypad = 10'd1 << 4;
    step(); step();
    lock = 1'b1;
    step();
    check("t5_locked_enablen", {15'd0, enc_enablen}, 16'd1);
    repeat (3) step();
    lock = 1'b0;
    repeat (8) step();
    check("t5_no_strobe_held", 16'(n_strobe - s0), 16'd0);
    keypad = 10'd0;
    step(); step();
    press_digit(4);
    check("t5_time", time_bcd, 16'h0004);
    lock = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clear_ignored_locked", time_bcd, 16'h0004);
    lock = 1'b0;
    step(); step();

    // Clear coincident with ACCEPT: strobe still fires, digit discarded.
    keypad = 10'd1 << 9;
    repeat (5) step();
    check("t6_strobe", {15'd0, digit_strobe}, 16'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_time", time_bcd, 16'h0000);
    check("t6_count", {13'd0, digit_count}, 16'd0);
    check("t6_value", {12'd0, digit_value}, 16'd9);
    keypad = 10'd0;
    step(); step();

`ifdef ENTRY_TIMEOUT_EN
    begin
      int found;
      logic [15:0] t_at;
      logic [2:0]  c_at;
      found = 0;
      t_at = 16'hffff;
      c_at = 3'd7;
      press_digit(6);
      check("t7_count_before", {13'd0, digit_count}, 16'd1);
      for (int i = 0; i < 40; i++) begin
        step();
        if (timeout && found == 0) begin
          found = 1;
          t_at = time_bcd;
          c_at = digit_count;
        end
      end
      check("t7_timeout_seen", 16'(found), 16'd1);
      check("t7_time_cleared", t_at, 16'h0000);
      check("t7_count_cleared", {13'd0, c_at}, 16'd0);
      check("t7_single_pulse", 16'(n_timeout), 16'd1);
    end
`else
    check("t7_timeout_tied_low", 16'(n_timeout), 16'd0);
`endif

    // Asynchronous reset mid-press returns everything to reset values at once.
    press_digit(2);
    check("t8_time_before", time_bcd, 16'h0002);
    keypad = 10'd1 << 8;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("t8_rst_time", time_bcd, 16'h0000);
    check("t8_rst_count", {13'd0, digit_count}, 16'd0);
    check("t8_rst_enablen", {15'd0, enc_enablen}, 16'd1);
    check("t8_rst_strobe", {15'd0, digit_strobe}, 16'd0);
    keypad = 10'd0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
